// File: rtl/dpram_b_arbiter_if.sv
// Port-B bus between the RAM, the video fetch, the loader, the clear control and the arbiter.
// The master side is the requesters plus the RAM; the slave side is the arbiter.
interface dpram_b_arbiter_if #(
    parameter int data_width_g = 8,
    parameter int addr_width_g = 14
);
    logic                    clr_start;
    logic                    clr_busy;
    logic                    vid_req;
    logic [addr_width_g-1:0] vid_addr;
    logic                    vid_ack;
    logic                    vid_valid;
    logic [data_width_g-1:0] vid_q;
    logic                    ld_req;
    logic [addr_width_g-1:0] ld_addr;
    logic [data_width_g-1:0] ld_data;
    logic                    ld_ack;
    logic                    ram_cs_b;
    logic                    ram_we_b;
    logic [addr_width_g-1:0] ram_ad_b;
    logic [data_width_g-1:0] ram_d_b;
    logic [data_width_g-1:0] ram_q_b;

    modport master (
        output clr_start, vid_req, vid_addr, ld_req, ld_addr, ld_data, ram_q_b,
        input  clr_busy, vid_ack, vid_valid, vid_q, ld_ack,
               ram_cs_b, ram_we_b, ram_ad_b, ram_d_b
    );

    modport slave (
        input  clr_start, vid_req, vid_addr, ld_req, ld_addr, ld_data, ram_q_b,
        output clr_busy, vid_ack, vid_valid, vid_q, ld_ack,
               ram_cs_b, ram_we_b, ram_ad_b, ram_d_b
    );
endinterface

// File: rtl/dpram_b_arbiter.sv
// Port-B sequencer: video reads (priority) and loader writes share one RAM port, plus a zero-fill engine.
// One access per cycle, registered outputs; read data returns two cycles after vid_ack.
module dpram_b_arbiter #(
    parameter int data_width_g = 8,
    parameter int addr_width_g = 14
) (
    input  logic                clk_sys,
    input  logic                reset,
    dpram_b_arbiter_if.slave    bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [addr_width_g-1:0] CNT_LAST = '1;

    logic [0:0]              state_q, state_d;
    logic [addr_width_g-1:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]              starve_q, starve_d;
    logic                    vid_ack_q, vid_ack_d;
    logic                    ld_ack_q, ld_ack_d;
    logic                    cs_q, cs_d;
    logic                    we_q, we_d;
    logic [addr_width_g-1:0] ad_q, ad_d;
    logic [data_width_g-1:0] dat_q, dat_d;
    logic                    rd_pend_q;
    logic                    vid_valid_q;
    logic [data_width_g-1:0] vid_q_q;

    logic vid_elig;
    logic ld_elig;
    logic ld_turn;

    // A requester acked last cycle may still show its req high; skip it once.
    assign vid_elig = bus.vid_req && !vid_ack_q;
    assign ld_elig  = bus.ld_req  && !ld_ack_q;
    assign ld_turn  = ld_elig && (!vid_elig || (starve_q == 2'd3));

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        starve_d  = starve_q;
        vid_ack_d = 1'b0;
        ld_ack_d  = 1'b0;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        ad_d      = ad_q;
        dat_d     = dat_q;

        case (state_q)
            S_CLEAR: begin
                we_d      = 1'b1;
                ad_d      = clr_cnt_q;
                dat_d     = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (bus.clr_start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else if (ld_turn) begin
                    we_d     = 1'b1;
                    ad_d     = bus.ld_addr;
                    dat_d    = bus.ld_data;
                    ld_ack_d = 1'b1;
                    starve_d = 2'd0;
                end else if (vid_elig) begin
                    cs_d      = 1'b1;
                    ad_d      = bus.vid_addr;
                    vid_ack_d = 1'b1;
                    if (bus.ld_req && (starve_q != 2'd3)) begin
                        starve_d = starve_q + 2'd1;
                    end
                end
            end
        endcase

        if (!bus.ld_req) begin
            starve_d = 2'd0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            starve_q    <= 2'd0;
            vid_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            ad_q        <= '0;
            dat_q       <= '0;
            rd_pend_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_q_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            starve_q    <= starve_d;
            vid_ack_q   <= vid_ack_d;
            ld_ack_q    <= ld_ack_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            ad_q        <= ad_d;
            dat_q       <= dat_d;
            // RAM captures the read one edge after vid_ack; its output is taken one edge later.
            rd_pend_q   <= vid_ack_q;
            vid_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                vid_q_q <= bus.ram_q_b;
            end
        end
    end

    assign bus.clr_busy  = (state_q == S_CLEAR);
    assign bus.vid_ack   = vid_ack_q;
    assign bus.ld_ack    = ld_ack_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_q     = vid_q_q;
    assign bus.ram_cs_b  = cs_q;
    assign bus.ram_we_b  = we_q;
    assign bus.ram_ad_b  = ad_q;
    assign bus.ram_d_b   = dat_q;

endmodule

// File: tb/tb_dpram_b_arbiter.sv
// Directed bench for dpram_b_arbiter with a behavioural port-B RAM and a write monitor.
module tb_dpram_b_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    dpram_b_arbiter_if #(.data_width_g(DW), .addr_width_g(AW)) bus ();

    dpram_b_arbiter #(.data_width_g(DW), .addr_width_g(AW)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk_sys) begin
        if (bus.ram_we_b) mem[bus.ram_ad_b] <= bus.ram_d_b;
        if (bus.ram_cs_b) bus.ram_q_b <= mem[bus.ram_ad_b];
    end

    int wr_addr_q[$];
    int wr_data_q[$];
    always @(posedge clk_sys) begin
        if (bus.ram_we_b) begin
            wr_addr_q.push_back(int'(bus.ram_ad_b));
            wr_data_q.push_back(int'(bus.ram_d_b));
        end
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t;
        bus.ld_addr = a;
        bus.ld_data = d;
        bus.ld_req  = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!bus.ld_ack && t < 50);
        if (!bus.ld_ack) check_eq("ld_ack_timeout", 0, 1);
        bus.ld_req = 1'b0;
    endtask

    task automatic vid_read(input logic [AW-1:0] a, output logic [DW-1:0] q);
        int t;
        bus.vid_addr = a;
        bus.vid_req  = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!bus.vid_ack && t < 50);
        if (!bus.vid_ack) check_eq("vid_ack_timeout", 0, 1);
        bus.vid_req = 1'b0;
        t = 0;
        do begin tick(); t++; end while (!bus.vid_valid && t < 10);
        if (!bus.vid_valid) check_eq("vid_valid_timeout", 0, 1);
        q = bus.vid_q;
    endtask

    initial begin
        int n, acks, bad, vrun, maxrun, lcount, g, v, nwr;
        int ack_cyc[$];
        logic [DW-1:0] q;

        bus.clr_start = 1'b0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.ld_req    = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;

        // Reset values
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("rst_clr_busy", bus.clr_busy, 0);
        check_eq("rst_vid_ack", bus.vid_ack, 0);
        check_eq("rst_ld_ack", bus.ld_ack, 0);
        check_eq("rst_vid_valid", bus.vid_valid, 0);
        check_eq("rst_vid_q", bus.vid_q, 0);
        check_eq("rst_ram_cs", bus.ram_cs_b, 0);
        check_eq("rst_ram_we", bus.ram_we_b, 0);
        check_eq("rst_ram_ad", bus.ram_ad_b, 0);
        check_eq("rst_ram_d", bus.ram_d_b, 0);

        // Full clear; a video request raised with clr_start must lose and stay pending
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.clr_start = 1'b1;
        bus.vid_req   = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        check_eq("clr_busy_rise", bus.clr_busy, 1);
        check_eq("clr_start_no_ack", bus.vid_ack, 0);
        n = 0;
        acks = 0;
        while (bus.clr_busy && n < DEPTH + 8) begin
            n++;
            if (bus.vid_ack || bus.ld_ack) acks++;
            bus.clr_start = (n == 5);
            tick();
        end
        bus.clr_start = 1'b0;
        check_eq("clr_busy_cycles", n, DEPTH);
        check_eq("clr_acks", acks, 0);
        tick();
        check_eq("vid_pending_after_clr", bus.vid_ack, 1);
        bus.vid_req = 1'b0;
        repeat (3) tick();
        check_eq("clr_write_count", wr_addr_q.size(), DEPTH);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != 0) bad++;
        check_eq("clr_write_order", bad, 0);

        // Single video read
        ld_write(14'h0123, 8'hA5);
        tick();
        bus.vid_addr = 14'h0123;
        bus.vid_req  = 1'b1;
        tick();
        check_eq("rd_vid_ack", bus.vid_ack, 1);
        check_eq("rd_ram_cs", bus.ram_cs_b, 1);
        check_eq("rd_ram_we", bus.ram_we_b, 0);
        check_eq("rd_ram_ad", bus.ram_ad_b, 32'h123);
        bus.vid_req = 1'b0;
        tick();
        check_eq("rd_valid_early", bus.vid_valid, 0);
        tick();
        check_eq("rd_valid", bus.vid_valid, 1);
        check_eq("rd_vid_q", bus.vid_q, 32'hA5);
        tick();
        check_eq("rd_valid_width", bus.vid_valid, 0);
        check_eq("rd_vid_q_hold", bus.vid_q, 32'hA5);

        // Loader burst with ld_req held high
        tick();
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.ld_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int t;
            bus.ld_addr = AW'(i);
            bus.ld_data = DW'(8'h10 + i);
            t = 0;
            do begin tick(); t++; end while (!bus.ld_ack && t < 20);
            if (bus.ld_ack) ack_cyc.push_back(cyc);
            else check_eq("burst_ack_timeout", 0, 1);
        end
        bus.ld_req = 1'b0;
        repeat (3) tick();
        check_eq("burst_write_count", wr_addr_q.size(), 8);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != 8'h10 + i) bad++;
        check_eq("burst_write_content", bad, 0);
        check_eq("burst_ack_count", ack_cyc.size(), 8);
        bad = 0;
        for (int k = 1; k < ack_cyc.size(); k++)
            if (ack_cyc[k] - ack_cyc[k-1] != 2) bad++;
        check_eq("burst_ack_spacing", bad, 0);
        for (int i = 0; i < 8; i++) begin
            vid_read(AW'(i), q);
            check_eq($sformatf("readback_%0d", i), q, 8'h10 + i);
        end

        // Both requesters held high; vid_addr toggles like a second video master
        bus.ld_addr  = 14'h0200;
        bus.ld_data  = 8'h5A;
        bus.vid_addr = 14'h0100;
        bus.vid_req  = 1'b1;
        bus.ld_req   = 1'b1;
        bad = 0; vrun = 0; maxrun = 0; lcount = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            bus.vid_addr = bus.vid_addr ^ 14'h0001;
            g = bus.vid_ack ? 1 : (bus.ld_ack ? 2 : 0);
            if (g != ((k % 2 == 0) ? 1 : 2)) bad++;
            if (g == 1) vrun++; else vrun = 0;
            if (vrun > maxrun) maxrun = vrun;
            if (g == 2) lcount++;
        end
        bus.vid_req = 1'b0;
        bus.ld_req  = 1'b0;
        repeat (3) tick();
        check_eq("both_pattern", bad, 0);
        check_eq("both_no_starve", (maxrun <= 3), 1);
        check_eq("both_ld_grants", lcount, 8);

        // Reset during a pending read suppresses vid_valid
        bus.vid_addr = 14'h0005;
        bus.vid_req  = 1'b1;
        tick();
        check_eq("rstrd_ack", bus.vid_ack, 1);
        reset = 1'b1;
        bus.vid_req = 1'b0;
        #1;
        check_eq("rstrd_ack_async", bus.vid_ack, 0);
        tick();
        reset = 1'b0;
        v = 0;
        repeat (4) begin tick(); if (bus.vid_valid) v++; end
        check_eq("rstrd_no_valid", v, 0);

        // Reset mid-clear at counter 5, then restart from address 0
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        repeat (5) tick();
        check_eq("mid_busy", bus.clr_busy, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_busy_async", bus.clr_busy, 0);
        check_eq("mid_we_async", bus.ram_we_b, 0);
        nwr = wr_addr_q.size();
        check_eq("mid_write_count", nwr, 4);
        check_eq("mid_last_addr", (nwr > 0) ? wr_addr_q[nwr-1] : -1, 3);
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        check_eq("mid_no_more_writes", wr_addr_q.size(), 4);
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        repeat (2) tick();
        check_eq("restart_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, 0);
        n = 0;
        while (bus.clr_busy && n < DEPTH + 8) begin tick(); n++; end
        check_eq("restart_done", bus.clr_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
